fp_align_shift_pipe: RTL and testbench
======================================

// Module: fp_align_shift_pipe
// PURPOSE
//  Pipelined, parametrised right-shift/extract unit for FP mantissa alignment and normalisation.
//  - Shifts a wide mantissa product right by a runtime amount, then extracts an OUT_W-bit field.
//  - Also returns guard, round and sticky (G/R/S) bits for the downstream rounder.
//  - Used in the FP multiplier after the product stage and before round/pack; reusable by the adder.
//  - One log-shifter level per pipeline stage, with a valid/ready handshake and backpressure.
// PARAMETERS
//  IN_W     50  input width (mantissa product)
//  SHIFT_W   8  width of the shift amount
//  OUT_W    23  extracted mantissa width
//  MSB_SEL  48  index of the extracted field MSB; field = [MSB_SEL : MSB_SEL-OUT_W+1]
//  TAG_W     8  opaque sideband (sign/exp/op id) carried with each item
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  rst_n      in   1        synchronous, active-low reset
//  in_valid   in   1        input item valid
//  in_ready   out  1        unit can accept this cycle
//  in_data    in   IN_W     value to shift
//  in_shamt   in   SHIFT_W  right-shift amount, unsigned
//  in_tag     in   TAG_W    sideband, passed through unchanged
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_mant   out  OUT_W    shifted[MSB_SEL -: OUT_W]
//  out_guard  out  1        shifted[MSB_SEL-OUT_W]
//  out_round  out  1        shifted[MSB_SEL-OUT_W-1]
//  out_sticky out  1        OR of shifted[MSB_SEL-OUT_W-2:0] and every 1-bit shifted out past bit 0
//  out_tag    out  TAG_W    in_tag of the same item
// BEHAVIOUR
//  - LEVELS = $clog2(IN_W); stages: S0 input reg, S1..SLEVELS one shift level each, then output reg.
//  - Latency is LEVELS+2 cycles from accept to out_valid (8 at defaults) when there is no stall.
//  - Throughput: 1 item/cycle.
//  - Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
//  - Accept when in_valid && in_ready. Retire when out_valid && out_ready.
//  - When !adv, every stage register and output holds. Outputs stay stable while out_valid && !out_ready.
//  - Bubbles travel as valid=0 slots; data regs in empty slots are don't-care, but outputs are forced to 0.
//  - S0 clamps the amount: shamt_c = (in_shamt >= IN_W) ? IN_W : in_shamt, width LEVELS+1.
//  - Level k (k = 0..LEVELS-1): if shamt_c[k], d = d >> 2^k and sticky |= OR of the 2^k bits dropped.
//  - Level LEVELS handles shamt_c == IN_W: d = 0 and sticky |= |d.
//  - Sticky starts at 0 in S0 and accumulates only through the levels. Tag and valid ride alongside.
//  - Output reg extracts mant/G/R and ORs the below-field bits into sticky.
//  - shamt = 0: exact extraction from in_data; sticky = OR of in_data[MSB_SEL-OUT_W-2:0].
//  - in_data bits above MSB_SEL are dropped when shamt = 0. The caller guarantees they are 0.
//  - Reset (rst_n = 0 at posedge): all valids are 0; out_mant/guard/round/sticky/tag are 0.
//  - Reset applies mid-stream as well: in-flight items are discarded, none emerges afterwards.
//  - in_ready is 1 in the first cycle after reset.
//  - Reset while out_valid && !out_ready drops the held item.
//  - Elaboration checks: MSB_SEL < IN_W; MSB_SEL-OUT_W-1 >= 0; 2**SHIFT_W - 1 >= 0 (any amount is legal).
// STRUCTURE
//  - fp_pkg holds: function clog2_w, typedef align_req_t {data, shamt, tag}, localparam LEVELS.
//  - Sub-module fp_shift_level (params W, K): one registered level with stage reg, enable, sticky merge.
//  - Instantiate LEVELS+1 copies of fp_shift_level in a generate loop; the last copy is the saturate level.
//  - The top level holds S0, the output extract register and the stall logic.
// TESTING
//  - Basic shift: data = 50'h2_0000_0000_0000 (bit 49), shamt = 1, out_ready = 1.
//    Expect 8 cycles later: mant = 23'h400000, G = R = S = 0, tag echoed.
//  - Sticky: data = 50'h2_0000_0000_0001, shamt = 1 -> mant = 23'h400000, sticky = 1.
//    Same data with shamt = 0 -> sticky = 1, since bit 0 lies inside the below-field region.
//  - Saturate: shamt = 8'd50 and shamt = 8'd255 with data = 1 -> mant = 0, G = R = 0, S = 1.
//    With data = 0 -> S = 0.
//  - Backpressure: stream 20 items with random shamt and hold out_ready = 0 for 5 cycles mid-stream.
//    Expect in_ready = 0 while stalled, out_* stable, and all 20 results in order matching the model.
//  - Reset mid-flight: accept 3 items, assert rst_n = 0 for 1 cycle.
//    Expect out_valid = 0 and outputs = 0 next cycle, with no stale item emerging in the following 10 cycles.
//  - Random: 10k items with constrained-random shamt (0..255) and out_ready toggling, checked against a reference model.

Source files
------------

// File: rtl/fp_align_shift_pipe_pkg.sv
// Shared constants, helper function and request type for the FP alignment shifter.
package fp_align_shift_pipe_pkg;

  localparam int DEF_IN_W    = 50;
  localparam int DEF_SHIFT_W = 8;
  localparam int DEF_OUT_W   = 23;
  localparam int DEF_MSB_SEL = 48;
  localparam int DEF_TAG_W   = 8;

  // Number of bits needed to index v positions (ceil(log2(v))).
  function automatic int clog2_w(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int LEVELS = clog2_w(DEF_IN_W);

  typedef struct packed {
    logic [DEF_IN_W-1:0]    data;
    logic [DEF_SHIFT_W-1:0] shamt;
    logic [DEF_TAG_W-1:0]   tag;
  } align_req_t;

endpackage

// File: rtl/fp_align_shift_pipe_if.sv
// Handshake bus of the alignment shifter: request side and result side.
interface fp_align_shift_pipe_if
#(
  parameter int IN_W    = fp_align_shift_pipe_pkg::DEF_IN_W,
  parameter int SHIFT_W = fp_align_shift_pipe_pkg::DEF_SHIFT_W,
  parameter int OUT_W   = fp_align_shift_pipe_pkg::DEF_OUT_W,
  parameter int TAG_W   = fp_align_shift_pipe_pkg::DEF_TAG_W
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic [SHIFT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_mant;
  logic               out_guard;
  logic               out_round;
  logic               out_sticky;
  logic [TAG_W-1:0]   out_tag;

  // Producer/consumer of the unit.
  modport master (
    output in_valid, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_mant, out_guard, out_round, out_sticky, out_tag
  );

  // The shifter itself.
  modport slave (
    input  in_valid, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_mant, out_guard, out_round, out_sticky, out_tag
  );
endinterface

// File: rtl/fp_shift_level.sv
// One log-shifter level: conditional right shift by 2^K with sticky merge,
// or (SAT) the clear-all level for an amount equal to the width.
module fp_shift_level
  import fp_align_shift_pipe_pkg::*;
#(
  parameter int W     = 50,
  parameter int K     = 0,
  parameter int SA_W  = 7,
  parameter int TAG_W = 8,
  parameter int SAT   = 0,
  parameter int REG   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [SA_W-1:0]  in_shamt,
  input  logic             in_sticky,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SA_W-1:0]  out_shamt,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);
  logic             valid_d;
  logic [W-1:0]     data_d;
  logic [SA_W-1:0]  shamt_d;
  logic             sticky_d;
  logic [TAG_W-1:0] tag_d;

  // Sideband fields ride along unchanged.
  always_comb begin
    valid_d = in_valid;
    shamt_d = in_shamt;
    tag_d   = in_tag;
  end

  if (SAT != 0) begin : g_sat
    // An amount equal to the width pushes every bit past bit 0.
    always_comb begin
      if (in_shamt == SA_W'(W)) begin
        data_d   = '0;
        sticky_d = in_sticky | (|in_data);
      end else begin
        data_d   = in_data;
        sticky_d = in_sticky;
      end
    end
  end else begin : g_shift
    localparam int SH = 1 << K;
    localparam logic [W-1:0] DROP_MASK = {W{1'b1}} >> (W - SH);

    // Shift by 2^K when this amount bit is set; fold dropped bits into sticky.
    always_comb begin
      if (in_shamt[K]) begin
        data_d   = in_data >> SH;
        sticky_d = in_sticky | (|(in_data & DROP_MASK));
      end else begin
        data_d   = in_data;
        sticky_d = in_sticky;
      end
    end
  end

  if (REG != 0) begin : g_reg
    logic             valid_q;
    logic [W-1:0]     data_q;
    logic [SA_W-1:0]  shamt_q;
    logic             sticky_q;
    logic [TAG_W-1:0] tag_q;

    // Stage register; holds whenever the pipe is stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q  <= 1'b0;
        data_q   <= '0;
        shamt_q  <= '0;
        sticky_q <= 1'b0;
        tag_q    <= '0;
      end else if (en) begin
        valid_q  <= valid_d;
        data_q   <= data_d;
        shamt_q  <= shamt_d;
        sticky_q <= sticky_d;
        tag_q    <= tag_d;
      end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_shamt  = shamt_q;
    assign out_sticky = sticky_q;
    assign out_tag    = tag_q;
  end else begin : g_comb
    logic unused_s;
    assign unused_s   = ^{clk, rst_n, en};
    assign out_valid  = valid_d;
    assign out_data   = data_d;
    assign out_shamt  = shamt_d;
    assign out_sticky = sticky_d;
    assign out_tag    = tag_d;
  end
endmodule

// File: rtl/fp_align_shift_pipe.sv
// Pipelined right-shift/extract unit for FP mantissa alignment with G/R/S output.
// S0 input reg, one registered log-shifter level per stage, a folded saturate
// level, then the extract register. A single global stall freezes every stage.
module fp_align_shift_pipe
  import fp_align_shift_pipe_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int MSB_SEL = DEF_MSB_SEL,
  parameter int TAG_W   = DEF_TAG_W
) (
  input logic                 clk,
  input logic                 rst_n,
  fp_align_shift_pipe_if.slave bus
);
  localparam int LV   = clog2_w(IN_W);
  localparam int SA_W = LV + 1;

  if (MSB_SEL >= IN_W) begin : g_bad_msb
    $error("MSB_SEL must be below IN_W");
  end
  if (MSB_SEL - OUT_W - 1 < 0) begin : g_bad_field
    $error("extract field plus guard/round must fit below MSB_SEL");
  end

  logic adv;

  logic             s0_valid_d, s0_valid_q;
  logic [IN_W-1:0]  s0_data_d,  s0_data_q;
  logic [SA_W-1:0]  s0_shamt_d, s0_shamt_q;
  logic [TAG_W-1:0] s0_tag_d,   s0_tag_q;

  logic             st_valid  [0:LV+1];
  logic [IN_W-1:0]  st_data   [0:LV+1];
  logic [SA_W-1:0]  st_shamt  [0:LV+1];
  logic             st_sticky [0:LV+1];
  logic [TAG_W-1:0] st_tag    [0:LV+1];

  logic             out_valid_d,  out_valid_q;
  logic [OUT_W-1:0] out_mant_d,   out_mant_q;
  logic             out_guard_d,  out_guard_q;
  logic             out_round_d,  out_round_q;
  logic             out_sticky_d, out_sticky_q;
  logic [TAG_W-1:0] out_tag_d,    out_tag_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // Capture the request and clamp the amount so everything >= IN_W saturates.
  always_comb begin
    s0_valid_d = bus.in_valid;
    s0_data_d  = bus.in_data;
    s0_tag_d   = bus.in_tag;
    if (int'(bus.in_shamt) >= IN_W) begin
      s0_shamt_d = SA_W'(IN_W);
    end else begin
      s0_shamt_d = SA_W'(bus.in_shamt);
    end
  end

  // S0 input register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
      s0_shamt_q <= '0;
      s0_tag_q   <= '0;
    end else if (adv) begin
      s0_valid_q <= s0_valid_d;
      s0_data_q  <= s0_data_d;
      s0_shamt_q <= s0_shamt_d;
      s0_tag_q   <= s0_tag_d;
    end
  end

  assign st_valid[0]  = s0_valid_q;
  assign st_data[0]   = s0_data_q;
  assign st_shamt[0]  = s0_shamt_q;
  assign st_sticky[0] = 1'b0;
  assign st_tag[0]    = s0_tag_q;

  for (genvar k = 0; k <= LV; k++) begin : g_lvl
    fp_shift_level #(
      .W     (IN_W),
      .K     (k),
      .SA_W  (SA_W),
      .TAG_W (TAG_W),
      .SAT   ((k == LV) ? 1 : 0),
      .REG   ((k < LV) ? 1 : 0)
    ) u_lvl (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (adv),
      .in_valid   (st_valid[k]),
      .in_data    (st_data[k]),
      .in_shamt   (st_shamt[k]),
      .in_sticky  (st_sticky[k]),
      .in_tag     (st_tag[k]),
      .out_valid  (st_valid[k+1]),
      .out_data   (st_data[k+1]),
      .out_shamt  (st_shamt[k+1]),
      .out_sticky (st_sticky[k+1]),
      .out_tag    (st_tag[k+1])
    );
  end

  // Bits above the field and the spent amount are not needed after the last level.
  logic unused_s;
  assign unused_s = ^{st_shamt[LV+1], st_data[LV+1][IN_W-1:MSB_SEL+1]};

  // Extract mantissa/G/R, fold the below-field bits into sticky, zero empty slots.
  always_comb begin
    out_valid_d = st_valid[LV+1];
    if (st_valid[LV+1]) begin
      out_mant_d   = st_data[LV+1][MSB_SEL -: OUT_W];
      out_guard_d  = st_data[LV+1][MSB_SEL-OUT_W];
      out_round_d  = st_data[LV+1][MSB_SEL-OUT_W-1];
      out_sticky_d = st_sticky[LV+1] | (|st_data[LV+1][MSB_SEL-OUT_W-2:0]);
      out_tag_d    = st_tag[LV+1];
    end else begin
      out_mant_d   = '0;
      out_guard_d  = 1'b0;
      out_round_d  = 1'b0;
      out_sticky_d = 1'b0;
      out_tag_d    = '0;
    end
  end

  // Output register; holds the result while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_mant_q   <= '0;
      out_guard_q  <= 1'b0;
      out_round_q  <= 1'b0;
      out_sticky_q <= 1'b0;
      out_tag_q    <= '0;
    end else if (adv) begin
      out_valid_q  <= out_valid_d;
      out_mant_q   <= out_mant_d;
      out_guard_q  <= out_guard_d;
      out_round_q  <= out_round_d;
      out_sticky_q <= out_sticky_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_guard  = out_guard_q;
  assign bus.out_round  = out_round_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_tag    = out_tag_q;
endmodule

// File: tb/tb_fp_align_shift_pipe.sv
// Self-checking bench: directed table, backpressure, mid-flight reset and a
// long random stream scored against a wide-arithmetic reference model.
module tb_fp_align_shift_pipe;
  import fp_align_shift_pipe_pkg::*;

  typedef struct packed {
    logic [22:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic [7:0]  tag;
  } res_t;

  typedef struct packed {
    align_req_t req;
    res_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  res_t q[$];
  logic hold_prev;
  res_t snap;
  logic accepted;
  logic retired;
  vec_t tv[13];

  fp_align_shift_pipe_if bus ();

  fp_align_shift_pipe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: shift the value into a wide window; whatever falls below bit 0 is lost.
  function automatic res_t model(input logic [49:0] d, input logic [7:0] sh, input logic [7:0] tg);
    logic [305:0] ext;
    logic [49:0]  s;
    res_t         r;
    ext    = {d, 256'd0} >> sh;
    s      = ext[305:256];
    r.mant = s[48:26];
    r.g    = s[25];
    r.r    = s[24];
    r.s    = (|s[23:0]) | (|ext[255:0]);
    r.tag  = tg;
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.mant = bus.out_mant;
    r.g    = bus.out_guard;
    r.r    = bus.out_round;
    r.s    = bus.out_sticky;
    r.tag  = bus.out_tag;
    return r;
  endfunction

  // One clock: drive at negedge, check outputs, score retire/accept, advance.
  task automatic step(input logic v, input logic [49:0] d, input logic [7:0] sh,
                      input logic [7:0] tg, input logic ordy,
                      input logic use_exp, input res_t exp_r);
    res_t cur;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_shamt  = sh;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    #1;
    cur = dut_res();
    chk("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || ordy));
    if (hold_prev) chk("held_stable", 64'({bus.out_valid, cur}), 64'({1'b1, snap}));
    if (!bus.out_valid) chk("idle_zero", 64'(cur), 64'd0);
    retired = 1'b0;
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        chk("result", 64'(cur), 64'(q[0]));
        q.pop_front();
        retired = 1'b1;
      end
    end
    hold_prev = bus.out_valid && !ordy;
    snap      = cur;
    accepted  = v && bus.in_ready;
    if (accepted) q.push_back(use_exp ? exp_r : model(d, sh, tg));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int n_cyc);
    n_cyc = 0;
    while (q.size() != 0 && n_cyc < budget) begin
      step(1'b0, 50'd0, 8'd0, 8'd0, 1'b1, 1'b0, '0);
      n_cyc++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  function automatic logic [49:0] rand_data();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return 50'd1 << $urandom_range(0, 49);
      1:       return r64[49:0];
      2:       return {1'b0, r64[48:0]};
      default: return {26'd0, r64[23:0]};
    endcase
  endfunction

  function automatic logic [7:0] rand_shamt();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'($urandom_range(0, 49));
      2:       return 8'($urandom_range(45, 55));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Stream n items; stall window [lo,hi) when rnd=0, random out_ready otherwise.
  task automatic run_stream(input int n, input int budget, input int lo, input int hi, input bit rnd);
    int          sent;
    int          cyc;
    logic        v;
    logic        ordy;
    logic [49:0] d;
    logic [7:0]  sh;
    logic [7:0]  tg;
    sent = 0;
    cyc  = 0;
    d    = rand_data();
    sh   = rand_shamt();
    tg   = 8'($urandom);
    while ((sent < n || q.size() != 0) && cyc < budget) begin
      if (rnd) begin
        v    = (sent < n) && ($urandom_range(0, 9) < 8);
        ordy = ($urandom_range(0, 9) < 7);
      end else begin
        v    = (sent < n);
        ordy = !(cyc >= lo && cyc < hi);
      end
      step(v, d, sh, tg, ordy, 1'b0, '0);
      if (accepted) begin
        sent++;
        d  = rand_data();
        sh = rand_shamt();
        tg = 8'($urandom);
      end
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'(n));
    chk("stream_empty", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic set_vec(input int i, input logic [49:0] d, input logic [7:0] sh,
                         input logic [22:0] m, input logic g, input logic r, input logic s);
    tv[i].req.data  = d;
    tv[i].req.shamt = sh;
    tv[i].req.tag   = 8'(8'h10 + i);
    tv[i].exp.mant  = m;
    tv[i].exp.g     = g;
    tv[i].exp.r     = r;
    tv[i].exp.s     = s;
    tv[i].exp.tag   = 8'(8'h10 + i);
  endtask

  initial begin
    int n_cyc;
    n_checks  = 0;
    n_fail    = 0;
    hold_prev = 1'b0;
    snap      = '0;
    accepted  = 1'b0;
    retired   = 1'b0;

    set_vec(0,  50'h2_0000_0000_0000, 8'd1,   23'h400000, 1'b0, 1'b0, 1'b0);
    set_vec(1,  50'h2_0000_0000_0001, 8'd1,   23'h400000, 1'b0, 1'b0, 1'b1);
    set_vec(2,  50'h2_0000_0000_0001, 8'd0,   23'h000000, 1'b0, 1'b0, 1'b1);
    set_vec(3,  50'h0_0000_0000_0001, 8'd50,  23'h000000, 1'b0, 1'b0, 1'b1);
    set_vec(4,  50'h0_0000_0000_0001, 8'd255, 23'h000000, 1'b0, 1'b0, 1'b1);
    set_vec(5,  50'h0_0000_0000_0000, 8'd50,  23'h000000, 1'b0, 1'b0, 1'b0);
    set_vec(6,  50'h0_0000_0000_0000, 8'd255, 23'h000000, 1'b0, 1'b0, 1'b0);
    set_vec(7,  50'h1_0000_0000_0000, 8'd0,   23'h400000, 1'b0, 1'b0, 1'b0);
    set_vec(8,  50'h0_0000_0200_0000, 8'd0,   23'h000000, 1'b1, 1'b0, 1'b0);
    set_vec(9,  50'h0_0000_0100_0000, 8'd0,   23'h000000, 1'b0, 1'b1, 1'b0);
    set_vec(10, 50'h1_0000_0000_0000, 8'd23,  23'h000000, 1'b1, 1'b0, 1'b0);
    set_vec(11, 50'h3_FFFF_FFFF_FFFF, 8'd49,  23'h000000, 1'b0, 1'b0, 1'b1);
    set_vec(12, 50'h1_FFFF_FC00_0000, 8'd0,   23'h7FFFFF, 1'b0, 1'b0, 1'b0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_outputs", 64'(dut_res()), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, one at a time through an empty pipe.
    for (int i = 0; i < 13; i++) begin
      step(1'b1, tv[i].req.data, tv[i].req.shamt, tv[i].req.tag, 1'b1, 1'b1, tv[i].exp);
      drain(20, n_cyc);
      chk("latency", 64'(n_cyc), 64'd8);
    end

    // Backpressure: 20 items, out_ready low for 5 cycles mid-stream.
    run_stream(20, 200, 12, 17, 1'b0);

    // Mid-flight reset with the head item held at the output.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_data(), rand_shamt(), 8'(8'hA0 + i), 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 50'd0, 8'd0, 8'd0, 1'b0, 1'b0, '0);
    end
    chk("pre_reset_held", 64'(bus.out_valid), 64'd1);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_outputs", 64'(dut_res()), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    q.delete();
    hold_prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 50'd0, 8'd0, 8'd0, 1'b1, 1'b0, '0);
      chk("no_stale", 64'(bus.out_valid), 64'd0);
    end

    // Long random stream with random backpressure.
    run_stream(10000, 40000, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
